// File: rtl/mstage_lsu_pkg.sv
// Shared constants for the memory stage: FSM encodings, load-type codes and
// pipeline-wide values such as the reset PC.
package mstage_lsu_pkg;

    localparam int          XLEN      = 32;
    localparam int          REG_AW    = 5;
    localparam int          MASK_W    = 8;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] RT_LB  = 3'd0;
    localparam logic [2:0] RT_LH  = 3'd1;
    localparam logic [2:0] RT_LW  = 3'd2;
    localparam logic [2:0] RT_LBU = 3'd4;
    localparam logic [2:0] RT_LHU = 3'd5;

endpackage

// File: rtl/mstage_lsu_if.sv
// Pipeline upstream, memory bus and downstream signals of the memory stage.
interface mstage_lsu_if;
    import mstage_lsu_pkg::*;

    logic                s_valid;
    logic                s_ready;
    logic                mvalidX;
    logic                mwenX;
    logic [MASK_W-1:0]   mwmaskX;
    logic [2:0]          mrtypeX;
    logic [XLEN-1:0]     addrX;
    logic [XLEN-1:0]     wdataX;
    logic [REG_AW-1:0]   rdX;
    logic [XLEN-1:0]     pcX;

    logic                req_valid;
    logic                req_wen;
    logic [XLEN-1:0]     req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic [MASK_W-1:0]   req_wmask;
    logic                req_ready;

    logic                resp_valid;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_err;
    logic                resp_ready;

    logic                m_valid;
    logic [XLEN-1:0]     resultM;
    logic [REG_AW-1:0]   rdM;
    logic [XLEN-1:0]     pcM;
    logic                loadM;
    logic                errM;
    logic                m_ready;

    // slave: the LSU itself; master: whatever surrounds it
    modport slave (
        input  s_valid, mvalidX, mwenX, mwmaskX, mrtypeX, addrX, wdataX, rdX, pcX,
        output s_ready,
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        output m_valid, resultM, rdM, pcM, loadM, errM,
        input  m_ready
    );

    modport master (
        output s_valid, mvalidX, mwenX, mwmaskX, mrtypeX, addrX, wdataX, rdX, pcX,
        input  s_ready,
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        input  m_valid, resultM, rdM, pcM, loadM, errM,
        output m_ready
    );

endinterface

// File: rtl/mstage_lsu_load_ext.sv
// Load byte-select and sign/zero extension. No alignment check: misaligned
// halfword/word loads see the shifted word with zeros shifted in at the top.
module load_ext
    import mstage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  rtype,
    output logic [31:0] ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        ext = shifted;
        case (rtype)
            RT_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
            RT_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
            RT_LW:   ext = shifted;
            RT_LBU:  ext = {24'h0, shifted[7:0]};
            RT_LHU:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/mstage_lsu.sv
// Memory stage load/store unit: one instruction in flight, walks
// IDLE -> REQ -> RESP -> DONE for memory ops, IDLE -> DONE otherwise.
module mstage_lsu
    import mstage_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mstage_lsu_if.slave bus
);

    lsu_state_e          state_q, state_d;

    logic                mwen_q;
    logic [MASK_W-1:0]   mwmask_q;
    logic [2:0]          mrtype_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [REG_AW-1:0]   rd_q;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     result_q;
    logic                load_q;
    logic                err_q;

    logic                accept;
    logic                resp_fire;
    logic [XLEN-1:0]     load_data;

    assign bus.s_ready    = (state_q == ST_IDLE);
    assign bus.req_valid  = (state_q == ST_REQ);
    assign bus.resp_ready = (state_q == ST_RESP);
    assign bus.m_valid    = (state_q == ST_DONE);

    assign bus.req_wen    = mwen_q;
    assign bus.req_addr   = addr_q;
    assign bus.req_wdata  = wdata_q;
    assign bus.req_wmask  = mwmask_q;

    assign bus.resultM    = result_q;
    assign bus.rdM        = rd_q;
    assign bus.pcM        = pc_q;
    assign bus.loadM      = load_q;
    assign bus.errM       = err_q;

    assign accept    = bus.s_valid & bus.s_ready;
    assign resp_fire = bus.resp_valid & bus.resp_ready;

    load_ext u_load_ext (
        .rdata  (bus.resp_rdata),
        .offset (addr_q[1:0]),
        .rtype  (mrtype_q),
        .ext    (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.s_valid)   state_d = bus.mvalidX ? ST_REQ : ST_DONE;
            ST_REQ:  if (bus.req_ready) state_d = ST_RESP;
            ST_RESP: if (bus.resp_valid) state_d = ST_DONE;
            ST_DONE: if (bus.m_ready)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mwen_q   <= 1'b0;
            mwmask_q <= '0;
            mrtype_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            pc_q     <= RESET_PC;
            result_q <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mwen_q   <= bus.mwenX;
                mwmask_q <= bus.mwmaskX;
                mrtype_q <= bus.mrtypeX;
                addr_q   <= bus.addrX;
                wdata_q  <= bus.wdataX;
                rd_q     <= bus.rdX;
                pc_q     <= bus.pcX;
                // non-memory ops complete here; memory ops fill results in RESP
                if (!bus.mvalidX) begin
                    result_q <= bus.addrX;
                    load_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
            end
            if (resp_fire) begin
                err_q    <= bus.resp_err;
                result_q <= mwen_q ? addr_q : load_data;
                load_q   <= ~mwen_q;
            end
        end
    end

endmodule

// File: tb/tb_mstage_lsu.sv
// Directed bench for mstage_lsu: passthrough, loads of each type, stalled
// store, downstream backpressure with error, and reset mid-transaction.
module tb_mstage_lsu;
    import mstage_lsu_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;

    mstage_lsu_if bus ();

    mstage_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && bus.req_valid && bus.req_ready) hs_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic mv, input logic wen, input logic [2:0] rt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [7:0] mask, input logic [4:0] rd,
                         input logic [31:0] pc);
        bus.s_valid = 1'b1;
        bus.mvalidX = mv;
        bus.mwenX   = wen;
        bus.mrtypeX = rt;
        bus.addrX   = addr;
        bus.wdataX  = wd;
        bus.mwmaskX = mask;
        bus.rdX     = rd;
        bus.pcX     = pc;
    endtask

    // load with immediate memory handshakes; m_valid expected 3 cycles after accept
    task automatic do_load(input string tag, input logic [2:0] rt,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp);
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
        bus.resp_err   = 1'b0;
        bus.m_ready    = 1'b1;
        offer(1'b1, 1'b0, rt, addr, 32'h0, 8'h00, 5'd7, 32'h8000_0200);
        step();
        bus.s_valid = 1'b0;
        check({tag, "_reqv"}, {31'd0, bus.req_valid}, 32'd1);
        check({tag, "_mv0"}, {31'd0, bus.m_valid}, 32'd0);
        step();
        check({tag, "_rspr"}, {31'd0, bus.resp_ready}, 32'd1);
        step();
        check({tag, "_mv"}, {31'd0, bus.m_valid}, 32'd1);
        check({tag, "_res"}, bus.resultM, exp);
        check({tag, "_ld"}, {31'd0, bus.loadM}, 32'd1);
        check({tag, "_err"}, {31'd0, bus.errM}, 32'd0);
        step();
        check({tag, "_sr"}, {31'd0, bus.s_ready}, 32'd1);
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        int hs_base;
        rst            = 1'b1;
        bus.s_valid    = 1'b0;
        bus.mvalidX    = 1'b0;
        bus.mwenX      = 1'b0;
        bus.mwmaskX    = 8'h00;
        bus.mrtypeX    = 3'd0;
        bus.addrX      = 32'h0;
        bus.wdataX     = 32'h0;
        bus.rdX        = 5'd0;
        bus.pcX        = 32'h0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        bus.m_ready    = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_sready", {31'd0, bus.s_ready}, 32'd1);
        check("rst_reqv",   {31'd0, bus.req_valid}, 32'd0);
        check("rst_rspr",   {31'd0, bus.resp_ready}, 32'd0);
        check("rst_mv",     {31'd0, bus.m_valid}, 32'd0);
        check("rst_res",    bus.resultM, 32'h0);
        check("rst_rd",     {27'd0, bus.rdM}, 32'd0);
        check("rst_pc",     bus.pcM, 32'h8000_0000);
        check("rst_ld",     {31'd0, bus.loadM}, 32'd0);
        check("rst_err",    {31'd0, bus.errM}, 32'd0);

        // non-memory passthrough
        bus.m_ready = 1'b1;
        offer(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 8'h00, 5'd5, 32'h8000_0100);
        step();
        bus.s_valid = 1'b0;
        check("alu_mv",  {31'd0, bus.m_valid}, 32'd1);
        check("alu_res", bus.resultM, 32'h0000_1234);
        check("alu_ld",  {31'd0, bus.loadM}, 32'd0);
        check("alu_rd",  {27'd0, bus.rdM}, 32'd5);
        check("alu_pc",  bus.pcM, 32'h8000_0100);
        check("alu_sr0", {31'd0, bus.s_ready}, 32'd0);
        step();
        check("alu_sr1", {31'd0, bus.s_ready}, 32'd1);
        check("alu_mv1", {31'd0, bus.m_valid}, 32'd0);

        do_load("lb",   RT_LB,  32'h8000_0003, 32'h80FF_7F01, 32'hFFFF_FF80);
        do_load("lhu",  RT_LHU, 32'h8000_0002, 32'hBEEF_0000, 32'h0000_BEEF);
        do_load("lh",   RT_LH,  32'h8000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF);
        do_load("lbu",  RT_LBU, 32'h8000_0001, 32'h1234_9A78, 32'h0000_009A);
        do_load("lwmis", RT_LW, 32'h8000_0001, 32'h1122_3344, 32'h0011_2233);
        do_load("rt3",  3'd3,   32'h8000_0002, 32'hCAFE_F00D, 32'h0000_CAFE);
        do_load("lw",   RT_LW,  32'h8000_0000, 32'hA5A5_0FF0, 32'hA5A5_0FF0);

        // store stalled by req_ready low for 5 cycles
        bus.req_ready = 1'b0;
        bus.m_ready   = 1'b1;
        hs_base       = hs_cnt;
        offer(1'b1, 1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 5'd9, 32'h8000_0300);
        step();
        bus.s_valid = 1'b0;
        bus.addrX   = 32'h5555_5555;
        bus.wdataX  = 32'h0;
        bus.mwmaskX = 8'hF0;
        bus.mwenX   = 1'b0;
        bus.resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("st_reqv",  {31'd0, bus.req_valid}, 32'd1);
            check("st_addr",  bus.req_addr, 32'h8000_0010);
            check("st_wdata", bus.req_wdata, 32'hDEAD_BEEF);
            check("st_mask",  {24'd0, bus.req_wmask}, 32'h0F);
            check("st_wen",   {31'd0, bus.req_wen}, 32'd1);
            check("st_rspr",  {31'd0, bus.resp_ready}, 32'd0);
            step();
        end
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        check("st_rspr1", {31'd0, bus.resp_ready}, 32'd1);
        step();
        bus.resp_valid = 1'b0;
        check("st_mv",  {31'd0, bus.m_valid}, 32'd1);
        check("st_res", bus.resultM, 32'h8000_0010);
        check("st_ld",  {31'd0, bus.loadM}, 32'd0);
        check("st_hs",  hs_cnt - hs_base, 32'd1);
        step();

        // error response with downstream backpressure
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        bus.resp_rdata = 32'h0000_00AB;
        bus.m_ready    = 1'b0;
        offer(1'b1, 1'b0, RT_LBU, 32'h8000_0020, 32'h0, 8'h00, 5'd3, 32'h8000_0400);
        step();
        bus.s_valid = 1'b0;
        step();
        step();
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        offer(1'b0, 1'b0, 3'd0, 32'h7777_7777, 32'h0, 8'h00, 5'd1, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("bp_mv",  {31'd0, bus.m_valid}, 32'd1);
            check("bp_res", bus.resultM, 32'h0000_00AB);
            check("bp_err", {31'd0, bus.errM}, 32'd1);
            check("bp_sr",  {31'd0, bus.s_ready}, 32'd0);
            check("bp_pc",  bus.pcM, 32'h8000_0400);
            step();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        step();
        check("bp_sr1", {31'd0, bus.s_ready}, 32'd1);
        check("bp_rd",  {27'd0, bus.rdM}, 32'd3);

        // reset while waiting for a response
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        offer(1'b1, 1'b0, RT_LW, 32'h8000_0040, 32'h0, 8'h00, 5'd4, 32'h8000_0500);
        step();
        bus.s_valid = 1'b0;
        step();
        check("rr_rspr0", {31'd0, bus.resp_ready}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_sr",   {31'd0, bus.s_ready}, 32'd1);
        check("rr_rspr", {31'd0, bus.resp_ready}, 32'd0);
        check("rr_mv",   {31'd0, bus.m_valid}, 32'd0);
        check("rr_pc",   bus.pcM, 32'h8000_0000);
        check("rr_res",  bus.resultM, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mstage_lsu.md
MSTAGE_LSU -- requirements
Module: mstage_lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have upstream handshake ports: s_valid in 1 (execute offers instr), s_ready out 1 (LSU can accept).
REQ-004 SHALL have upstream payload inputs: mvalidX 1 (memory op), mwenX 1 (store), mwmaskX 8 (write mask), mrtypeX 3 (load type), addrX 32 (ALU result/address), wdataX 32 (store data), rdX 5, pcX 32.
REQ-005 SHALL have memory request outputs: req_valid 1, req_wen 1, req_addr 32, req_wdata 32, req_wmask 8; and input req_ready 1.
REQ-006 SHALL have memory response ports: resp_valid in 1, resp_rdata in 32 (aligned word at addr & ~3), resp_err in 1, resp_ready out 1.
REQ-007 SHALL have downstream outputs: m_valid 1, resultM 32 (load data or passthrough addrX), rdM 5, pcM 32, loadM 1 (resultM came from memory), errM 1; and input m_ready 1.

Function
REQ-008 SHALL implement FSM with states IDLE, REQ, RESP, DONE.
REQ-009 SHALL assert s_ready only in IDLE, req_valid only in REQ, resp_ready only in RESP, m_valid only in DONE.
REQ-010 SHALL, in IDLE on s_valid, latch all X payload and go to REQ if mvalidX=1, else to DONE with resultM=addrX, loadM=0, errM=0.
REQ-011 SHALL, in REQ, hold req_addr=latched addr, req_wen=latched mwen, req_wdata=latched wdata, req_wmask=latched mwmask stable until req_ready; on req_valid & req_ready go to RESP.
REQ-012 SHALL, in RESP on resp_valid, latch errM=resp_err, and for loads set resultM=extended data and loadM=1; for stores set resultM=latched addr and loadM=0; then go to DONE.
REQ-013 SHALL extract load data by shifting resp_rdata right by 8*addr[1:0], then extend per mrtype: 0 LB sign-ext byte, 1 LH sign-ext half, 2 LW full word, 4 LBU zero-ext byte, 5 LHU zero-ext half; codes 3,6,7 SHALL yield the full shifted word.
REQ-014 SHALL NOT check alignment; misaligned half/word uses shifted bits with zero fill above bit 31.
REQ-015 SHALL, in DONE, hold all M outputs stable until m_ready; on m_ready return to IDLE.
REQ-016 SHALL NOT accept new upstream work in the cycle DONE completes (no bypass); minimum issue interval is 2 cycles for non-memory ops and 4 for memory ops.
REQ-017 SHALL ignore resp_valid outside RESP and req_ready outside REQ.
REQ-018 SHALL treat resp_valid in the same cycle as entry to RESP as not-yet-seen; the response is sampled from the following cycle onward.
REQ-019 SHALL keep resultM, rdM, pcM, loadM, errM unchanged in every state except the capturing transitions.

Reset
REQ-020 SHALL on rst go to IDLE regardless of current state, dropping any in-flight request or response.
REQ-021 SHALL reset outputs to: resultM=0, rdM=0, pcM=32'h80000000, loadM=0, errM=0, internal latched payload=0; handshake outputs follow state (s_ready=1, others 0).
REQ-022 SHALL rely on the memory slave sharing rst; no recovery of orphaned bus transactions.

Structure
REQ-023 SHALL place state encodings (IDLE=0, REQ=1, RESP=2, DONE=3) and mrtype codes in a shared package alongside existing pipeline constants.
REQ-024 SHALL factor load byte-select and extension into one combinational sub-module, load_ext (inputs rdata 32, offset 2, rtype 3; output 32).

Verification
REQ-025 Non-memory op: addrX=32'h1234, mvalidX=0, s_valid one cycle, m_ready=1 -> m_valid next cycle, resultM=32'h1234, loadM=0, s_ready back at 1 the cycle after.
REQ-026 LB at addrX=32'h80000003, resp_rdata=32'h80FF7F01, req_ready and resp_valid immediate -> resultM=32'hFFFFFF80, loadM=1, m_valid 3 cycles after accept.
REQ-027 LHU at addrX=32'h80000002, resp_rdata=32'hBEEF0000 -> resultM=32'h0000BEEF; same with LH -> 32'hFFFFBEEF.
REQ-028 Store addr 32'h80000010, wdata 32'hDEADBEEF, mwmask 8'h0F, req_ready held low 5 cycles -> req_* stable all 5 cycles, single handshake, resultM=32'h80000010, loadM=0.
REQ-029 Backpressure and error: m_ready low 4 cycles with resp_err=1 -> m_valid, resultM, errM=1 stable, s_ready=0 throughout; s_valid ignored.
REQ-030 rst asserted while in RESP -> next cycle state IDLE, s_ready=1, resp_ready=0, m_valid=0, pcM=32'h80000000.
